// File: rtl/neural_network_pkg.sv
// Shared sizes, opcodes, instruction layout and controller states.
package neural_network_pkg;

  localparam int NU_COUNT     = 4;
  localparam int Q_SIZE       = 16;
  localparam int Q_FRAC       = 8;
  localparam int XY_MEM_DEPTH = 8;
  localparam int W_MEM_DEPTH  = 8;
  localparam int MOV_LENGTH   = 8;
  localparam int PROG_DEPTH   = 8;
  localparam int LANE_W       = $clog2(NU_COUNT);

  typedef enum logic [1:0] {
    INST_NOP     = 2'd0,
    INST_FORWARD = 2'd1,
    INST_HALT    = 2'd2
  } opcode_t;

  typedef struct packed {
    opcode_t                 opcode;
    logic [XY_MEM_DEPTH-1:0] x_addr;
    logic [XY_MEM_DEPTH-1:0] y_addr;
    logic [W_MEM_DEPTH-1:0]  w_addr;
    logic [MOV_LENGTH-1:0]   length0;
    logic [MOV_LENGTH-1:0]   length1;
  } instr_t;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    MAC   = 2'd1,
    WRITE = 2'd2,
    HALT  = 2'd3
  } ctrl_state_t;

endpackage

// File: rtl/neural_network_controller.sv
// Program sequencer: fetches instructions and times the MAC and WRITE phases.
module controller
  import neural_network_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  instr_t                prog_word_i,
  output logic [PROG_DEPTH-1:0] pc_o,
  output logic                  fetch_o,
  output logic                  clear_o,
  output logic                  mac_en_o,
  output logic                  wr_en_o,
  output logic [LANE_W-1:0]     wr_lane_o
);

  localparam logic [MOV_LENGTH-1:0] LEN_ONE = 1;
  localparam logic [PROG_DEPTH-1:0] PC_ONE  = 1;

  ctrl_state_t           state_q;
  logic [PROG_DEPTH-1:0] pc_q;
  logic [MOV_LENGTH-1:0] cnt_q;
  instr_t                instruction;
  logic [MOV_LENGTH-1:0] length0;
  logic [MOV_LENGTH-1:0] length1;

  assign length0 = instruction.length0;
  assign length1 = instruction.length1;

  // Sequencer FSM: FETCH is one cycle, MAC and WRITE run for their lengths.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= FETCH;
      pc_q        <= '0;
      cnt_q       <= '0;
      instruction <= '0;
    end else begin
      case (state_q)
        FETCH: begin
          instruction <= prog_word_i;
          pc_q        <= pc_q + PC_ONE;
          cnt_q       <= '0;
          case (prog_word_i.opcode)
            INST_FORWARD: begin
              if (prog_word_i.length0 != '0)
                state_q <= MAC;
              else if (prog_word_i.length1 != '0)
                state_q <= WRITE;
              else
                state_q <= FETCH;
            end
            INST_HALT: state_q <= HALT;
            default:   state_q <= FETCH;
          endcase
        end
        MAC: begin
          if (cnt_q == length0 - LEN_ONE) begin
            cnt_q   <= '0;
            state_q <= (length1 != '0) ? WRITE : FETCH;
          end else begin
            cnt_q <= cnt_q + LEN_ONE;
          end
        end
        WRITE: begin
          if (cnt_q == length1 - LEN_ONE) begin
            cnt_q   <= '0;
            state_q <= FETCH;
          end else begin
            cnt_q <= cnt_q + LEN_ONE;
          end
        end
        HALT:    state_q <= HALT;
        default: state_q <= FETCH;
      endcase
    end
  end

  // Strobes are suppressed while reset is held so an aborted WRITE stores nothing.
  assign pc_o      = pc_q;
  assign fetch_o   = (state_q == FETCH) && !reset;
  assign clear_o   = fetch_o && (prog_word_i.opcode == INST_FORWARD);
  assign mac_en_o  = (state_q == MAC) && !reset;
  assign wr_en_o   = (state_q == WRITE) && !reset;
  assign wr_lane_o = cnt_q[LANE_W-1:0];

endmodule

// File: rtl/neural_network_mac.sv
// One saturating fixed-point multiply-accumulate lane.
module mac_unit
  import neural_network_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     en,
  input  logic signed [Q_SIZE-1:0] x,
  input  logic signed [Q_SIZE-1:0] w,
  output logic signed [Q_SIZE-1:0] acc_o
);

  logic signed [Q_SIZE-1:0]   mac_reg;
  logic signed [2*Q_SIZE-1:0] prod;
  logic signed [2*Q_SIZE-1:0] term;
  logic        [2*Q_SIZE:0]   sum;

  // Clamp a wide sum to the signed Q_SIZE range: in range iff all bits above
  // the Q_SIZE sign bit agree with it.
  function automatic logic signed [Q_SIZE-1:0] sat(input logic [2*Q_SIZE:0] v);
    logic [Q_SIZE+1:0] hi;
    hi = v[2*Q_SIZE:Q_SIZE-1];
    if ((hi == '0) || (hi == '1))
      return v[Q_SIZE-1:0];
    else if (v[2*Q_SIZE])
      return {1'b1, {(Q_SIZE-1){1'b0}}};
    else
      return {1'b0, {(Q_SIZE-1){1'b1}}};
  endfunction

  // Full-width signed product, rescaled to Q format, added with one guard bit.
  always_comb begin
    prod = x * w;
    term = prod >>> Q_FRAC;
    sum  = {{(Q_SIZE+1){mac_reg[Q_SIZE-1]}}, mac_reg} + {term[2*Q_SIZE-1], term};
  end

  // Accumulator: reset and clear win over accumulation; otherwise hold.
  always_ff @(posedge clk) begin
    if (reset || clear)
      mac_reg <= '0;
    else if (en)
      mac_reg <= sat(sum);
  end

  assign acc_o = mac_reg;

endmodule

// File: rtl/neural_network.sv
// Fully-connected layer core: program/XY/W memories, controller and MAC lanes.
module neural_network
  import neural_network_pkg::*;
#(
  parameter string PROG_FILE = "prog.hex",
  parameter string XY_FILE   = "xy.hex",
  parameter string W_FILE    = "w.hex"
) (
  input logic clk,
  input logic reset
);

  localparam int PROG_WORDS = 1 << PROG_DEPTH;
  localparam int XY_WORDS   = 1 << XY_MEM_DEPTH;
  localparam int W_WORDS    = 1 << W_MEM_DEPTH;
  localparam logic [XY_MEM_DEPTH-1:0] XY_ONE = 1;
  localparam logic [W_MEM_DEPTH-1:0]  W_ONE  = 1;

  instr_t                     prog_mem [PROG_WORDS];
  logic signed [Q_SIZE-1:0]   xy_mem   [XY_WORDS];
  logic [NU_COUNT*Q_SIZE-1:0] w_mem    [W_WORDS];

  logic [XY_MEM_DEPTH-1:0] xy_read_addr;
  logic [XY_MEM_DEPTH-1:0] xy_write_addr;
  logic [W_MEM_DEPTH-1:0]  w_read_addr;

  logic [PROG_DEPTH-1:0]      pc;
  instr_t                     prog_word;
  logic                       fetch, clear, mac_en, wr_en;
  logic [LANE_W-1:0]          wr_lane;
  logic signed [Q_SIZE-1:0]   xy_rd;
  logic [NU_COUNT*Q_SIZE-1:0] w_rd;
  logic signed [Q_SIZE-1:0]   mac_val [NU_COUNT];

  assign prog_word = prog_mem[pc];
  assign xy_rd     = xy_mem[xy_read_addr];
  assign w_rd      = w_mem[w_read_addr];

  controller controller (
    .clk         (clk),
    .reset       (reset),
    .prog_word_i (prog_word),
    .pc_o        (pc),
    .fetch_o     (fetch),
    .clear_o     (clear),
    .mac_en_o    (mac_en),
    .wr_en_o     (wr_en),
    .wr_lane_o   (wr_lane)
  );

  // Address registers: loaded at fetch, stepped (wrapping) during MAC/WRITE.
  always_ff @(posedge clk) begin
    if (fetch) begin
      xy_read_addr  <= prog_word.x_addr;
      w_read_addr   <= prog_word.w_addr;
      xy_write_addr <= prog_word.y_addr;
    end else if (mac_en) begin
      xy_read_addr <= xy_read_addr + XY_ONE;
      w_read_addr  <= w_read_addr + W_ONE;
    end else if (wr_en) begin
      xy_write_addr <= xy_write_addr + XY_ONE;
    end
  end

  // XY write-back port: one accumulator lane per WRITE cycle.
  always_ff @(posedge clk) begin
    if (wr_en)
      xy_mem[xy_write_addr] <= mac_val[wr_lane];
  end

  for (genvar i = 0; i < NU_COUNT; i++) begin : mac_gen
    mac_unit mac_unit (
      .clk   (clk),
      .reset (reset),
      .clear (clear),
      .en    (mac_en),
      .x     (xy_rd),
      .w     (w_rd[i*Q_SIZE +: Q_SIZE]),
      .acc_o (mac_val[i])
    );
  end

endmodule

// File: tb/tb_neural_network.sv
// Directed bench for neural_network: vector table plus multi-cycle sequences.
module tb_neural_network;
  import neural_network_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  neural_network #(.PROG_FILE(""), .XY_FILE(""), .W_FILE("")) dut (
    .clk   (clk),
    .reset (reset)
  );

  int total = 0;
  int bad   = 0;

  logic [15:0] mac_q [4];
  assign mac_q[0] = dut.mac_gen[0].mac_unit.mac_reg;
  assign mac_q[1] = dut.mac_gen[1].mac_unit.mac_reg;
  assign mac_q[2] = dut.mac_gen[2].mac_unit.mac_reg;
  assign mac_q[3] = dut.mac_gen[3].mac_unit.mac_reg;

  typedef struct packed {
    logic [15:0]       x;
    logic [3:0][15:0]  w;
    logic [3:0][15:0]  e;
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic instr_t mk(input opcode_t op, input int x, input int y, input int w,
                                input int l0, input int l1);
    instr_t r;
    r.opcode  = op;
    r.x_addr  = 8'(x);
    r.y_addr  = 8'(y);
    r.w_addr  = 8'(w);
    r.length0 = 8'(l0);
    r.length1 = 8'(l1);
    return r;
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic begin_test();
    reset = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 256; i++) begin
      dut.prog_mem[i] <= '0;
      dut.xy_mem[i]   <= '0;
      dut.w_mem[i]    <= '0;
    end
  endtask

  task automatic go(input string tag);
    check({tag, "_rst_state"}, 16'(dut.controller.state_q), 16'(FETCH));
    check({tag, "_rst_pc"}, 16'(dut.controller.pc_q), 16'h0000);
    check({tag, "_rst_mac0"}, mac_q[0], 16'h0000);
    reset = 1'b0;
  endtask

  task automatic load_main(input int l1);
    dut.xy_mem[2] <= 16'h0100;
    dut.xy_mem[3] <= 16'h0200;
    dut.xy_mem[4] <= 16'h0300;
    dut.xy_mem[5] <= 16'h0400;
    for (int i = 12; i < 16; i++) dut.w_mem[i] <= {16'h0000, 16'h0000, 16'h0080, 16'h0100};
    dut.prog_mem[0] <= mk(INST_FORWARD, 2, 0, 12, 4, l1);
  endtask

  initial begin
    // lanes listed 3..0 in each packed constant
    vecs[0] = '{x: 16'h0100, w: {16'h0000, 16'hFF00, 16'h0080, 16'h0100},
                             e: {16'h0000, 16'hFE00, 16'h0100, 16'h0200}};
    vecs[1] = '{x: 16'h7F00, w: {16'hFF00, 16'h0100, 16'h8100, 16'h7F00},
                             e: {16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF}};
    vecs[2] = '{x: 16'hFF80, w: {16'h0040, 16'h0001, 16'hFF80, 16'h0200},
                             e: {16'hFFC0, 16'hFFFE, 16'h0080, 16'hFE00}};
    vecs[3] = '{x: 16'h0001, w: {16'h7FFF, 16'h0100, 16'h00FF, 16'h0080},
                             e: {16'h00FE, 16'h0002, 16'h0000, 16'h0000}};

    // Table: two-step dot product per vector, four lanes written to xy[16..19]
    for (int v = 0; v < 4; v++) begin
      begin_test();
      dut.xy_mem[0]   <= vecs[v].x;
      dut.xy_mem[1]   <= vecs[v].x;
      dut.w_mem[0]    <= vecs[v].w;
      dut.w_mem[1]    <= vecs[v].w;
      dut.prog_mem[0] <= mk(INST_FORWARD, 0, 16, 0, 2, 4);
      dut.prog_mem[1] <= mk(INST_HALT, 0, 0, 0, 0, 0);
      go($sformatf("vec%0d", v));
      step(7);
      for (int j = 0; j < 4; j++)
        check($sformatf("vec%0d_lane%0d", v, j), dut.xy_mem[16+j], vecs[v].e[j]);
      check($sformatf("vec%0d_xy20", v), dut.xy_mem[20], 16'h0000);
      step(1);
      check($sformatf("vec%0d_halt", v), 16'(dut.controller.state_q), 16'(HALT));
    end

    // Main FORWARD, cycle-exact write-back, then HALT freeze
    begin_test();
    load_main(2);
    dut.prog_mem[1] <= mk(INST_HALT, 0, 0, 0, 0, 0);
    go("main");
    step(6);
    check("main_c6_state", 16'(dut.controller.state_q), 16'(WRITE));
    check("main_c6_xy0", dut.xy_mem[0], 16'h0A00);
    check("main_c6_xy1", dut.xy_mem[1], 16'h0000);
    step(1);
    check("main_xy1", dut.xy_mem[1], 16'h0500);
    check("main_mac0", mac_q[0], 16'h0A00);
    check("main_mac1", mac_q[1], 16'h0500);
    check("main_mac2", mac_q[2], 16'h0000);
    check("main_xy2", dut.xy_mem[2], 16'h0100);
    check("main_xy5", dut.xy_mem[5], 16'h0400);
    step(1);
    check("halt_state", 16'(dut.controller.state_q), 16'(HALT));
    check("halt_pc", 16'(dut.controller.pc_q), 16'h0002);
    step(20);
    check("halt_pc_20", 16'(dut.controller.pc_q), 16'h0002);
    check("halt_state_20", 16'(dut.controller.state_q), 16'(HALT));
    check("halt_mac0", mac_q[0], 16'h0A00);
    check("halt_mac1", mac_q[1], 16'h0500);
    check("halt_xy0", dut.xy_mem[0], 16'h0A00);
    check("halt_xy2", dut.xy_mem[2], 16'h0100);
    check("halt_xy6", dut.xy_mem[6], 16'h0000);

    // L0=0 after a FORWARD with L1=0: MACs cleared at fetch, zeros written
    begin_test();
    load_main(0);
    dut.xy_mem[0] <= 16'h5555;
    for (int i = 40; i < 45; i++) dut.xy_mem[i] <= 16'h1234;
    dut.prog_mem[1] <= mk(INST_FORWARD, 0, 40, 0, 0, 4);
    dut.prog_mem[2] <= mk(INST_HALT, 0, 0, 0, 0, 0);
    go("l0z");
    step(5);
    check("l0z_mac0_first", mac_q[0], 16'h0A00);
    check("l0z_state_fetch", 16'(dut.controller.state_q), 16'(FETCH));
    check("l0z_xy0_kept", dut.xy_mem[0], 16'h5555);
    step(1);
    check("l0z_mac0_clr", mac_q[0], 16'h0000);
    check("l0z_state_write", 16'(dut.controller.state_q), 16'(WRITE));
    step(4);
    for (int j = 0; j < 4; j++)
      check($sformatf("l0z_xy%0d", 40 + j), dut.xy_mem[40+j], 16'h0000);
    check("l0z_xy44", dut.xy_mem[44], 16'h1234);
    check("l0z_state_end", 16'(dut.controller.state_q), 16'(FETCH));

    // Reset during MAC aborts and clears accumulators
    begin_test();
    load_main(2);
    dut.prog_mem[1] <= mk(INST_HALT, 0, 0, 0, 0, 0);
    go("rst");
    step(3);
    check("rst_pre_state", 16'(dut.controller.state_q), 16'(MAC));
    check("rst_pre_mac0", mac_q[0], 16'h0300);
    reset = 1'b1;
    step(1);
    check("rst_state", 16'(dut.controller.state_q), 16'(FETCH));
    check("rst_pc", 16'(dut.controller.pc_q), 16'h0000);
    for (int j = 0; j < 4; j++)
      check($sformatf("rst_mac%0d", j), mac_q[j], 16'h0000);
    check("rst_xy0", dut.xy_mem[0], 16'h0000);
    reset = 1'b0;
    step(7);
    check("rst_rerun_xy0", dut.xy_mem[0], 16'h0A00);

    // Read addresses wrap around the top of XY and W memories
    begin_test();
    dut.xy_mem[254] <= 16'h0100;
    dut.xy_mem[255] <= 16'h0200;
    dut.xy_mem[0]   <= 16'h0300;
    dut.xy_mem[1]   <= 16'h0400;
    dut.xy_mem[2]   <= 16'h6400;
    dut.w_mem[254]  <= 64'h0000_0000_0000_0100;
    dut.w_mem[255]  <= 64'h0000_0000_0000_0100;
    dut.w_mem[0]    <= 64'h0000_0000_0000_0100;
    dut.w_mem[1]    <= 64'h0000_0000_0000_0100;
    dut.w_mem[2]    <= 64'h0000_0000_0000_7F00;
    dut.prog_mem[0] <= mk(INST_FORWARD, 254, 10, 254, 4, 1);
    dut.prog_mem[1] <= mk(INST_HALT, 0, 0, 0, 0, 0);
    go("wrap");
    step(5);
    check("wrap_xy_raddr", 16'(dut.xy_read_addr), 16'h0002);
    check("wrap_w_raddr", 16'(dut.w_read_addr), 16'h0002);
    check("wrap_mac0", mac_q[0], 16'h0A00);
    step(1);
    check("wrap_xy10", dut.xy_mem[10], 16'h0A00);
    check("wrap_waddr", 16'(dut.xy_write_addr), 16'h000B);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
